// File: rtl/pal_cfg_loader.sv
// Serial-to-parallel configuration loader for the PAL array: shifts a MSB-first stream into a shadow
// register and commits it atomically. Optional even-parity trailing bit enabled by PAL_CFG_PARITY_EN.
module pal_cfg_loader #(
  parameter  int N_INPUTS  = 8,
  parameter  int N_TERMS   = 12,
  parameter  int N_OUTPUTS = 4,
  localparam int CFG_BITS  = 2 * N_INPUTS * N_TERMS + N_TERMS * N_OUTPUTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                bit_valid,
  input  logic                bit_in,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                cfg_valid,
  output logic                cfg_done,
  output logic                busy,
  output logic                cfg_err
);

`ifdef PAL_CFG_PARITY_EN
  localparam int STREAM_LEN = CFG_BITS + 1;
`else
  localparam int STREAM_LEN = CFG_BITS;
`endif
  localparam int CNT_W = $clog2(CFG_BITS + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
`ifdef PAL_CFG_PARITY_EN
  logic                err_q, err_d;
  logic                par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef PAL_CFG_PARITY_EN
      err_q    <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef PAL_CFG_PARITY_EN
      err_q    <= err_d;
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
`ifdef PAL_CFG_PARITY_EN
    err_d    = err_q;
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_start) begin
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef PAL_CFG_PARITY_EN
          err_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        // A restart takes priority over a coincident data bit, which is dropped.
        if (load_start) begin
          cnt_d = '0;
`ifdef PAL_CFG_PARITY_EN
          err_d = 1'b0;
`endif
        end else if (bit_valid) begin
`ifdef PAL_CFG_PARITY_EN
          if (cnt_q < CNT_W'(CFG_BITS)) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], bit_in};
          end else begin
            par_d = bit_in;
          end
`else
          shadow_d = {shadow_q[CFG_BITS-2:0], bit_in};
`endif
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STREAM_LEN - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
`ifdef PAL_CFG_PARITY_EN
        if ((^shadow_q) == par_q) begin
          cfg_d   = shadow_q;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
`else
        cfg_d   = shadow_q;
        valid_d = 1'b1;
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_out   = cfg_q;
  assign cfg_valid = valid_q;
  assign cfg_done  = done_q;
  assign busy      = (state_q != IDLE);
`ifdef PAL_CFG_PARITY_EN
  assign cfg_err   = err_q;
`else
  assign cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader with a 10-bit configuration (N_INPUTS=2, N_TERMS=2, N_OUTPUTS=1).
// Parity cases are compiled only when PAL_CFG_PARITY_EN is defined.
module tb_pal_cfg_loader;
  localparam int CB = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic [CB-1:0] cfg_out;
  logic          cfg_valid;
  logic          cfg_done;
  logic          busy;
  logic          cfg_err;

  int n_asserts = 0;
  int n_fails   = 0;

  pal_cfg_loader #(
    .N_INPUTS (2),
    .N_TERMS  (2),
    .N_OUTPUTS(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .cfg_done  (cfg_done),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Full load; returns after edge E+1 (commit visible), and checks the E+2 pulse drop.
  task automatic load_word(input logic [CB-1:0] w, input logic [CB-1:0] exp_out);
    start();
    for (int i = 0; i < CB; i++) send_bit(w[CB-1-i]);
`ifdef PAL_CFG_PARITY_EN
    send_bit(^w);
`endif
    chk("commit_busy_E", {31'd0, busy}, 32'd1);
    tick();
    chk("commit_out", {22'd0, cfg_out}, {22'd0, exp_out});
    chk("commit_done", {31'd0, cfg_done}, 32'd1);
    chk("commit_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("done_drop", {31'd0, cfg_done}, 32'd0);
  endtask

  logic [CB-1:0] pat;
  logic          done_seen;

  initial begin
    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_out", {22'd0, cfg_out}, 32'd0);
    chk("rst_valid", {31'd0, cfg_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, cfg_done}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);

    // Basic load 1011001101, cfg_out held at 0 during SHIFT
    pat = 10'b1011001101;
    start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < CB; i++) begin
      send_bit(pat[CB-1-i]);
      chk("shift_hold0", {22'd0, cfg_out}, 32'd0);
    end
`ifdef PAL_CFG_PARITY_EN
    send_bit(1'b0);
`endif
    chk("E_done", {31'd0, cfg_done}, 32'd0);
    tick();
    chk("basic_out", {22'd0, cfg_out}, 32'h2CD);
    chk("basic_done", {31'd0, cfg_done}, 32'd1);
    chk("basic_valid", {31'd0, cfg_valid}, 32'd1);
    tick();
    chk("basic_done_drop", {31'd0, cfg_done}, 32'd0);

    // Load all-ones, then partial load with gaps leaves it untouched
    load_word(10'h3FF, 10'h3FF);
    start();
    for (int i = 0; i < 10; i++) begin
      bit_valid = (i % 2 == 0);
      bit_in    = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    chk("partial_hold", {22'd0, cfg_out}, 32'h3FF);
    chk("partial_busy", {31'd0, busy}, 32'd1);
    // Restart from SHIFT with 10 zeros; 9 must not commit
    start();
    for (int i = 0; i < CB - 1; i++) send_bit(1'b0);
    tick();
    chk("restart9_busy", {31'd0, busy}, 32'd1);
    chk("restart9_hold", {22'd0, cfg_out}, 32'h3FF);
    send_bit(1'b0);
`ifdef PAL_CFG_PARITY_EN
    send_bit(1'b0);
`endif
    tick();
    chk("restart_out", {22'd0, cfg_out}, 32'h000);
    chk("restart_done", {31'd0, cfg_done}, 32'd1);
    chk("valid_sticky", {31'd0, cfg_valid}, 32'd1);
    tick();

    // Coincident load_start + bit_valid drops the bit
    pat = 10'h2A5;
    start();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    load_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    load_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    for (int i = 0; i < CB - 1; i++) send_bit(pat[CB-1-i]);
    tick();
    chk("drop_no_done", {31'd0, cfg_done}, 32'd0);
    chk("drop_busy", {31'd0, busy}, 32'd1);
    send_bit(pat[0]);
`ifdef PAL_CFG_PARITY_EN
    send_bit(^pat);
`endif
    tick();
    chk("drop_out", {22'd0, cfg_out}, 32'h2A5);
    chk("drop_done", {31'd0, cfg_done}, 32'd1);
    tick();

    // Reset mid-load on a configured block
    start();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out", {22'd0, cfg_out}, 32'd0);
    chk("midrst_valid", {31'd0, cfg_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    // Bits without load_start are ignored
    done_seen = 1'b0;
    for (int i = 0; i < CB + 1; i++) begin
      send_bit(1'b1);
      done_seen = done_seen | cfg_done | busy;
    end
    tick(); tick();
    chk("nostart_out", {22'd0, cfg_out}, 32'd0);
    chk("nostart_act", {31'd0, done_seen | busy | cfg_done}, 32'd0);

`ifdef PAL_CFG_PARITY_EN
    // Good parity
    load_word(10'b1000000001, 10'b1000000001);
    chk("par_ok_err", {31'd0, cfg_err}, 32'd0);
    // Bad parity
    start();
    pat = 10'b1000000001;
    for (int i = 0; i < CB; i++) send_bit(pat[CB-1-i]);
    send_bit(1'b1);
    tick();
    chk("par_bad_out", {22'd0, cfg_out}, 32'h201);
    chk("par_bad_err", {31'd0, cfg_err}, 32'd1);
    chk("par_bad_done", {31'd0, cfg_done}, 32'd1);
    tick();
    start();
    chk("par_err_clr", {31'd0, cfg_err}, 32'd0);
    for (int i = 0; i < CB + 1; i++) send_bit(1'b0);
    tick(); tick();
`else
    chk("err_tied0", {31'd0, cfg_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pal_cfg_loader.md
# pal_cfg_loader

Serial configuration loader for the PAL array. Receives the configuration bitstream one bit per cycle, assembles it in a shadow register, and atomically commits it to the parallel `cfg_out` vector that drives the `cfg_in` pins of every AND-plane and OR-plane crosspoint. The array keeps running on the previous configuration until a complete, valid stream has been received.

## Interface
- `N_INPUTS`, 8, number of PAL inputs; each has a true and a complement literal per product term.
- `N_TERMS`, 12, number of product terms.
- `N_OUTPUTS`, 4, number of OR-plane outputs.
- `CFG_BITS` (localparam) = 2·N_INPUTS·N_TERMS + N_TERMS·N_OUTPUTS; default 240.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle request to begin or restart a load.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_in`  in  1  serial configuration bit, MSB-first.
- `cfg_out`  out  CFG_BITS  active configuration to crosspoints; AND-plane field in the upper bits, OR-plane field in the lower bits.
- `cfg_valid`  out  1  at least one successful commit since reset.
- `cfg_done`  out  1  one-cycle pulse at the end of each commit.
- `busy`  out  1  high in SHIFT and COMMIT.
- `cfg_err`  out  1  parity failure on the last load (only with `PAL_CFG_PARITY_EN`; otherwise tied 0).

## Operation
- Reset values: `cfg_out` = 0, so the AND plane passes neutral 1s, the OR plane passes neutral 0s, and all outputs read 0. All of `cfg_valid`, `cfg_done`, `busy` and `cfg_err` reset to 0. State resets to IDLE, and the counter and shadow register reset to 0.
- State machine:
  - IDLE:
    - `load_start` clears the counter, clears `cfg_err`, and moves to SHIFT.
    - `bit_valid` is ignored.
  - SHIFT:
    - On each `bit_valid`: shadow = {shadow[CFG_BITS-2:0], bit_in} and the counter increments.
    - When the accepted bit brings the counter to STREAM_LEN, the state moves to COMMIT. STREAM_LEN = CFG_BITS, or CFG_BITS+1 with parity.
    - A `load_start` in SHIFT restarts the load: counter = 0, shadow contents are don't-care, and `cfg_out` is untouched. If `load_start` and `bit_valid` occur in the same cycle, the restart wins and the bit is dropped.
  - COMMIT (one cycle):
    - `cfg_out` ← shadow.
    - `cfg_valid` ← 1.
    - `cfg_done` is pulsed.
    - The state returns to IDLE.
    - `load_start` and `bit_valid` are ignored in this cycle.
- The first bit received lands in `cfg_out[CFG_BITS-1]`.
- `cfg_out` changes only in COMMIT and on reset, never bit-by-bit.
- `cfg_valid` stays 1 across later loads and clears only on reset.
- Reset mid-load: everything returns to reset values, including `cfg_out` = 0.
- The counter is wide enough to hold CFG_BITS+1 and never wraps.

## Timing
- The last stream bit is captured at edge E; the state is COMMIT during the following cycle.
- At edge E+1: `cfg_out` is updated, `cfg_done` = 1, `cfg_valid` = 1, and the state is IDLE. `busy` falls at E+1.
- At edge E+2: `cfg_done` returns to 0.
- `busy` rises at the edge that samples `load_start` in IDLE.
- Minimum load time: STREAM_LEN+2 cycles from `load_start`, with `bit_valid` held high from the cycle after `load_start`.
- Gaps in `bit_valid` stretch SHIFT indefinitely. There is no timeout.

## Configuration
- `PAL_CFG_PARITY_EN` defined:
  - The stream carries one extra trailing bit; STREAM_LEN = CFG_BITS+1.
  - The trailing bit must equal the XOR of the CFG_BITS data bits (even parity). It is not shifted into the shadow register.
  - In COMMIT with a mismatch: `cfg_out` and `cfg_valid` are unchanged, `cfg_err` ← 1, and `cfg_done` still pulses.
  - `cfg_err` clears on the next `load_start` or on reset.
- `PAL_CFG_PARITY_EN` undefined: STREAM_LEN = CFG_BITS, there is no parity logic, and `cfg_err` is constant 0.

## Test plan
Benches use N_INPUTS=2, N_TERMS=2, N_OUTPUTS=1, giving CFG_BITS=10.
- Reset, then idle for 5 cycles -> `cfg_out`=10'h000, `cfg_valid`=0, `busy`=0, `cfg_done`=0.
- `load_start`, then 10 back-to-back bits 1,0,1,1,0,0,1,1,0,1 -> `cfg_out`=10'b1011001101 two edges after the last bit, a single-cycle `cfg_done`, `cfg_valid`=1. `cfg_out` holds 0 throughout SHIFT.
- Load 10'h3FF, then start a second load and send 5 bits with `bit_valid` toggling -> `cfg_out` stays 10'h3FF and `busy`=1. Then `load_start` plus 10 zero bits -> `cfg_out`=10'h000 and exactly 10 bits are counted.
- Assert `load_start` and `bit_valid` together mid-SHIFT -> that bit is dropped, and 10 further bits are required before commit.
- Assert `rst` after 6 of 10 bits on a configured block -> `cfg_out`=0, `cfg_valid`=0, state IDLE. Bits sent without `load_start` leave `cfg_out` unchanged.
- With `PAL_CFG_PARITY_EN`: data 10'b1000000001 with parity 0 -> commit, `cfg_err`=0. The same data with parity 1 -> `cfg_out` is unchanged, `cfg_err`=1, and `cfg_done` pulses. `cfg_err` clears on the next `load_start`.
